// File: rtl/mcu_fsm.sv
// Main control unit: sequences fetch, decode, execute and LSU handshakes,
// maintains the IR and retired-instruction count, and traps on illegal opcodes or bus timeout.
module mcu_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             MCU_CLOCK_50,
    input  logic             MCU_RESET_InHigh,
    input  logic             MCU_Imem_Ack,
    input  logic [31:0]      MCU_Imem_Data_InBUS,
    input  logic             MCU_Lsu_Ready,
    input  logic             MCU_Lsu_Done,
    output logic [2:0]       MCU_State_OutBUS,
    output logic [31:0]      MCU_Ir_OutBUS,
    output logic             MCU_Imem_Req,
    output logic             MCU_Lsu_Valid,
    output logic             MCU_Pc_Write,
    output logic             MCU_Load_Wb,
    output logic             MCU_Trap,
    output logic [CNT_W-1:0] MCU_Retired_OutBUS
);

    typedef enum logic [2:0] {
        S_RESET    = 3'b000,
        S_FETCH    = 3'b001,
        S_DECODE   = 3'b010,
        S_EXEC     = 3'b011,
        S_MEM_REQ  = 3'b100,
        S_MEM_RESP = 3'b101,
        S_TRAP     = 3'b110,
        S_BAD      = 3'b111
    } state_t;

    // Watchdog count never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state, state_next;
    logic [31:0]      ir;
    logic [CNT_W-1:0] retired;
    logic [WD_W-1:0]  wd_cnt;
    logic [6:0]       op;
    logic             wait_state, awaited, wd_expired;
    logic             imem_req, lsu_valid, pc_write, load_wb;

    function automatic logic is_legal(input logic [6:0] opc);
        case (opc)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: is_legal = 1'b1;
            default:                                         is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] opc);
        is_mem = (opc[6] == 1'b0) && (opc[4:0] == 5'b00011);
    endfunction

    assign op = ir[6:0];

    always_comb begin
        wait_state = 1'b0;
        awaited    = 1'b1;
        case (state)
            S_FETCH:    begin wait_state = 1'b1; awaited = MCU_Imem_Ack;  end
            S_MEM_REQ:  begin wait_state = 1'b1; awaited = MCU_Lsu_Ready; end
            S_MEM_RESP: begin wait_state = 1'b1; awaited = MCU_Lsu_Done;  end
            default:    ;
        endcase
        wd_expired = (TIMEOUT > 0) && wait_state && !awaited && (wd_cnt == WD_LAST);
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        lsu_valid  = 1'b0;
        pc_write   = 1'b0;
        load_wb    = 1'b0;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (MCU_Imem_Ack)    state_next = S_DECODE;
                else if (wd_expired) state_next = S_TRAP;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (!is_legal(op)) begin
                    state_next = S_TRAP;
                end else if (is_mem(op)) begin
                    state_next = S_MEM_REQ;
                end else begin
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_MEM_REQ: begin
                lsu_valid = 1'b1;
                if (MCU_Lsu_Ready)   state_next = S_MEM_RESP;
                else if (wd_expired) state_next = S_TRAP;
            end
            S_MEM_RESP: begin
                if (MCU_Lsu_Done) begin
                    pc_write   = 1'b1;
                    load_wb    = ~ir[5];
                    state_next = S_FETCH;
                end else if (wd_expired) begin
                    state_next = S_TRAP;
                end
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    // Any state change clears the watchdog, which covers every entry into a wait state.
    always_ff @(posedge MCU_CLOCK_50 or posedge MCU_RESET_InHigh) begin
        if (MCU_RESET_InHigh) begin
            state   <= S_RESET;
            ir      <= '0;
            retired <= '0;
            wd_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH && MCU_Imem_Ack)
                ir <= MCU_Imem_Data_InBUS;
            if (pc_write)
                retired <= retired + 1'b1;
            if (state_next != state)
                wd_cnt <= '0;
            else if ((TIMEOUT > 0) && wait_state)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign MCU_State_OutBUS   = state;
    assign MCU_Ir_OutBUS      = ir;
    assign MCU_Imem_Req       = imem_req;
    assign MCU_Lsu_Valid      = lsu_valid;
    assign MCU_Pc_Write       = pc_write;
    assign MCU_Load_Wb        = load_wb;
    assign MCU_Trap           = (state == S_TRAP);
    assign MCU_Retired_OutBUS = retired;

endmodule
